vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares the single-port video RAM between the VGA scan-out path (reads, absolute priority, fixed latency) and game logic (writes, valid/ready).
- Game-logic writes are buffered in a small write FIFO and drained into free RAM cycles.
- Runs a hardware screen-clear sequence on request.
- Sits between the game FSM / VGA timing generator and the VRAM block inside Top.

Parameters:
- ADDR_W, 15, VRAM word address width.
- DATA_W, 12, pixel word width ({r,g,b} 4:4:4).
- DEPTH, 19200, number of VRAM words (160x120); clear covers 0..DEPTH-1.
- FIFO_DEPTH, 4, write FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous, active-low reset.
- scan_req  in  1  scan-out read request this cycle.
- scan_addr  in  ADDR_W  scan-out read address.
- scan_valid  out  1  scan_data valid.
- scan_data  out  DATA_W  read pixel.
- wr_valid  in  1  game write offered.
- wr_ready  out  1  FIFO accepts write.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write pixel.
- clr_start  in  1  one-cycle pulse: clear whole VRAM.
- clr_color  in  DATA_W  clear value, sampled with clr_start.
- clr_done  out  1  one-cycle pulse at clear completion.
- busy  out  1  FIFO non-empty or clear in progress.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with !ram_we.

Behaviour:
- Clocking/reset: one clock, clk; reset is asynchronous and active-low on rstn. Reset clears state to IDLE, FIFO to empty, clear counter to 0, and scan_valid/clr_done/busy to 0.
- Reset values: scan_data=0, wr_ready=1. RAM port outputs are combinational and are 0 during reset.
- Port mux priority, per cycle:
  - 1) scan_req: ram_en=1, ram_we=0, ram_addr=scan_addr.
  - 2) CLEAR state: write clr_color to clear counter.
  - 3) FIFO non-empty: pop head, write it.
  - 4) Otherwise ram_en=0.
- Read latency: scan_req high in cycle n gives scan_valid=1 in cycle n+2, with scan_data from a register on ram_rdata. Back-to-back reads are fully pipelined, one per cycle.
- FIFO:
  - Push on wr_valid&&wr_ready.
  - wr_ready = !full && state==IDLE.
  - Simultaneous push and pop when full is not allowed (ready is low). When non-full, push and pop in the same cycle keep the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count is width clog2(FIFO_DEPTH)+1.
- Ordering: FIFO writes reach RAM in acceptance order. No write is ever dropped.
- FSM states:
  - IDLE: clr_start goes to DRAIN and latches clr_color.
  - DRAIN: wr_ready=0; FIFO empty goes to CLEAR with counter=0.
  - CLEAR: on each cycle without scan_req, write and increment. After writing DEPTH-1, go to IDLE and pulse clr_done in the following cycle.
- clr_start outside IDLE is ignored.
- scan_req in DRAIN/CLEAR is still served and stalls progress that cycle.
- busy = (count!=0) || state!=IDLE.
- Reset asserted mid-clear or mid-drain: pending FIFO entries are discarded, no further RAM writes, state returns to IDLE.
- Addresses >=DEPTH on wr_addr are passed through unchecked.

Optional Feature:
- Macro: VRAM_BYPASS_EN.
- Defined: in cycle n, scan_addr is compared against every valid FIFO entry and against a write issued to RAM in the same cycle. On a match, scan_data in cycle n+2 returns the youngest matching data instead of ram_rdata. The bypass data is pipelined alongside the read.
- Undefined: no comparison. A scan read of an address with a pending write returns the old RAM contents; the display tolerates one stale pixel.

Decomposition:
- Shared package vram_pkg:
  - ADDR_W/DATA_W defaults.
  - pixel_t and vaddr_t typedefs.
  - State enum arb_state_t {IDLE, DRAIN, CLEAR}.
- One sub-module, vram_wfifo: synchronous FIFO with push/pop/full/empty, exposing entries for bypass compare.

Test Plan:
- Reset: hold rstn=0 with wr_valid=1 -> scan_valid=0, wr_ready=1, ram_en=0, busy=0. Release -> one write accepted per cycle until 4 pending.
- Read latency: scan_req every cycle for addr 0..7, RAM preloaded word=addr -> scan_valid from cycle 2, scan_data 0..7 consecutively, no writes interleaved.
- Starve and drain: scan_req held high 20 cycles with 6 writes offered (0x100<-0xABC ...) -> wr_ready low after 4 accepts. Scan drops -> writes hit RAM in order, remaining 2 accepted, busy falls after last write.
- Clear: 2 writes pending, then clr_start with clr_color=0x0F0 -> pending writes land first. All 19200 words become 0x0F0, clr_done pulses once, wr_ready=0 throughout.
- Clear stall and abort: scan_req on alternate cycles during CLEAR -> clear takes ~38400 cycles, reads correct. Assert rstn=0 at word 5000 -> words >=5000 unchanged, state IDLE.
- Bypass (VRAM_BYPASS_EN): write 0x123 to addr 42 while scan_req blocks draining, then scan addr 42 -> scan_data=0x123. Without the macro -> old value.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and default sizes for the VRAM arbiter slice.
// Optional scan-read bypass of pending writes is enabled with VRAM_BYPASS_EN.
package vram_pkg;

    localparam int VRAM_ADDR_W     = 15;
    localparam int VRAM_DATA_W     = 12;
    localparam int VRAM_DEPTH      = 19200;
    localparam int VRAM_FIFO_DEPTH = 4;

    typedef logic [VRAM_ADDR_W-1:0] vaddr_t;
    typedef logic [VRAM_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        CLEAR
    } arb_state_t;

endpackage

// File: rtl/vram_wfifo.sv
// Small synchronous write FIFO holding {addr, data} game writes until a free RAM cycle.
// With VRAM_BYPASS_EN it also reports the youngest pending entry matching a lookup address.
module vram_wfifo #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 4,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
`ifdef VRAM_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_data
`endif
);

    logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

`ifdef VRAM_BYPASS_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (mem_addr[rd_ptr + PTR_W'(i)] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = mem_data[rd_ptr + PTR_W'(i)];
            end
        end
    end
`endif

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out reads first, then screen clear, then buffered game writes.
// Define VRAM_BYPASS_EN to forward pending FIFO data to scan reads of the same address.
//
// state | meaning
// IDLE  | normal operation, FIFO accepts writes, FIFO drains into free RAM cycles
// DRAIN | clear requested, writes refused, waiting for pending writes to land
// CLEAR | writing clr_color to every word, stalled by scan reads
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int DEPTH      = VRAM_DEPTH,
    parameter int FIFO_DEPTH = VRAM_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_valid,
    output logic [DATA_W-1:0] scan_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_done,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    arb_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_color_q;
    logic              clr_last;

    logic              f_push;
    logic              f_pop;
    logic              f_full;
    logic              f_empty;
    logic [CNT_W-1:0]  f_count;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              rd_p1;
    logic [DATA_W-1:0] rd_word;

`ifdef VRAM_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic              byp_hit_p1;
    logic [DATA_W-1:0] byp_data_p1;
`endif

    assign wr_ready = !f_full && (state == IDLE);
    assign f_push   = wr_valid && wr_ready;
    assign busy     = (f_count != '0) || (state != IDLE);
    assign clr_last = (clr_cnt == ADDR_W'(DEPTH - 1));

    vram_wfifo #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (f_push),
        .push_addr  (wr_addr),
        .push_data  (wr_data),
        .pop        (f_pop),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (f_full),
        .empty      (f_empty),
        .count      (f_count)
`ifdef VRAM_BYPASS_EN
        ,
        .lookup_addr (scan_addr),
        .lookup_hit  (byp_hit),
        .lookup_data (byp_data)
`endif
    );

    // Port outputs are forced off while reset is held so nothing reaches the RAM.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        f_pop     = 1'b0;
        if (rstn) begin
            if (scan_req) begin
                ram_en   = 1'b1;
                ram_addr = scan_addr;
            end else if (state == CLEAR) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_cnt;
                ram_wdata = clr_color_q;
            end else if (!f_empty) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = head_addr;
                ram_wdata = head_data;
                f_pop     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            clr_cnt     <= '0;
            clr_color_q <= '0;
            clr_done    <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state       <= DRAIN;
                        clr_color_q <= clr_color;
                    end
                end
                DRAIN: begin
                    if (f_empty) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (!scan_req) begin
                        if (clr_last) begin
                            state    <= IDLE;
                            clr_done <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A scan read always owns the port, so no RAM write can collide in the same cycle;
    // only still-pending FIFO entries need forwarding.
    always_comb begin
        rd_word = ram_rdata;
`ifdef VRAM_BYPASS_EN
        if (byp_hit_p1) rd_word = byp_data_p1;
`endif
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_p1      <= 1'b0;
            scan_valid <= 1'b0;
            scan_data  <= '0;
`ifdef VRAM_BYPASS_EN
            byp_hit_p1  <= 1'b0;
            byp_data_p1 <= '0;
`endif
        end else begin
            rd_p1      <= scan_req;
            scan_valid <= rd_p1;
            if (rd_p1) scan_data <= rd_word;
`ifdef VRAM_BYPASS_EN
            byp_hit_p1  <= scan_req && byp_hit;
            byp_data_p1 <= byp_data;
`endif
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised scoreboard bench for vram_arbiter against a queue-based model of the arbitration rules.
// Honours VRAM_BYPASS_EN the same way the design does.
module tb_vram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 19200;
    localparam int FDEPTH = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              scan_req = 1'b0;
    logic [ADDR_W-1:0] scan_addr = '0;
    logic              scan_valid;
    logic [DATA_W-1:0] scan_data;
    logic              wr_valid = 1'b0;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr_start = 1'b0;
    logic [DATA_W-1:0] clr_color = '0;
    logic              clr_done;
    logic              busy;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FDEPTH)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_valid (scan_valid),
        .scan_data  (scan_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_done   (clr_done),
        .busy       (busy),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                if (int'(ram_addr) < DEPTH) ram[ram_addr] <= ram_wdata;
            end else begin
                ram_rdata <= (int'(ram_addr) < DEPTH) ? ram[ram_addr] : '0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int addr; int data; } wexp_t;
    typedef struct { int data; int when; } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    total = 0;
    int    passed = 0;
    int    done_seen = 0;

    // Reference model state
    int    mref [DEPTH];
    wexp_t pend[$];
    int    mode = 0;        // 0 idle, 1 waiting for pending writes, 2 clearing
    int    mcnt = 0;
    int    mcolor = 0;
    bit    done_flag = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        #1;
        if (ram_en && ram_we) begin
            if (wq.size() == 0) begin
                check("unexpected_ram_write_addr", int'(ram_addr), -1);
            end else begin
                wexp_t e;
                e = wq.pop_front();
                check("ram_write_addr", int'(ram_addr), e.addr);
                check("ram_write_data", int'(ram_wdata), e.data);
            end
        end
        if (scan_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_scan_valid_data", int'(scan_data), -1);
            end else begin
                rexp_t r;
                r = rq.pop_front();
                check("scan_data", int'(scan_data), r.data);
                check("scan_latency_cycle", cyc, r.when);
            end
        end
    end

    // Advance the model by one clock using the inputs just driven, then check per-cycle outputs.
    task automatic step();
        bit    exp_ready, exp_busy, exp_done, acc;
        int    pstart, mode0, rd;
        wexp_t e;
        exp_ready = (pend.size() < FDEPTH) && (mode == 0);
        exp_busy  = (pend.size() != 0) || (mode != 0);
        exp_done  = done_flag;
        done_flag = 1'b0;
        pstart    = pend.size();
        mode0     = mode;
        acc       = wr_valid && exp_ready;
        if (scan_req) begin
            rd = mref[int'(scan_addr)];
`ifdef VRAM_BYPASS_EN
            foreach (pend[i]) if (pend[i].addr == int'(scan_addr)) rd = pend[i].data;
`endif
            rq.push_back('{rd, cyc + 2});
        end else if (mode0 == 2) begin
            mref[mcnt] = mcolor;
            wq.push_back('{mcnt, mcolor});
            if (mcnt == DEPTH - 1) begin
                mode      = 0;
                done_flag = 1'b1;
            end else begin
                mcnt++;
            end
        end else if (pstart != 0) begin
            e = pend.pop_front();
            if (e.addr < DEPTH) mref[e.addr] = e.data;
            wq.push_back(e);
        end
        if (mode0 == 0 && clr_start) begin
            mode   = 1;
            mcolor = int'(clr_color);
        end else if (mode0 == 1 && pstart == 0) begin
            mode = 2;
            mcnt = 0;
        end
        if (acc) pend.push_back('{int'(wr_addr), int'(wr_data)});
        #1;
        check("wr_ready", int'(wr_ready), int'(exp_ready));
        check("busy", int'(busy), int'(exp_busy));
        check("clr_done", int'(clr_done), int'(exp_done));
        if (clr_done) done_seen++;
    endtask

    task automatic drive_idle();
        scan_req  = 1'b0;
        wr_valid  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic quiet(input int max);
        int n;
        n = 0;
        while ((pend.size() != 0 || mode != 0) && n < max) begin
            @(negedge clk);
            drive_idle();
            step();
            n++;
        end
        check("quiet_pending_left", pend.size(), 0);
        repeat (3) begin
            @(negedge clk);
            drive_idle();
            step();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int j, bad, n;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = DATA_W'(i);
            mref[i] = i & 12'hFFF;
        end

        // Reset held with activity on the inputs
        scan_req = 1'b1;
        wr_valid = 1'b1;
        scan_addr = 15'd3;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("rst_scan_valid", int'(scan_valid), 0);
            check("rst_wr_ready", int'(wr_ready), 1);
            check("rst_ram_en", int'(ram_en), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_scan_data", int'(scan_data), 0);
        end

        // Release while scan blocks the port: FIFO fills to 4, then refuses
        @(negedge clk);
        rstn = 1'b1;
        j = 0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            scan_req  = 1'b1;
            scan_addr = ADDR_W'(16'h100 + (k % 6));
            wr_valid  = (j < 6);
            wr_addr   = ADDR_W'(16'h100 + j);
            wr_data   = DATA_W'(12'hABC - j);
            if (wr_valid && pend.size() < FDEPTH && mode == 0) j++;
            step();
        end
        while (j < 6) begin
            @(negedge clk);
            scan_req = 1'b0;
            wr_valid = 1'b1;
            wr_addr  = ADDR_W'(16'h100 + j);
            wr_data  = DATA_W'(12'hABC - j);
            if (pend.size() < FDEPTH && mode == 0) j++;
            step();
        end
        quiet(50);

        // Pipelined reads of addresses 0..7
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive_idle();
            scan_req  = 1'b1;
            scan_addr = ADDR_W'(k);
            step();
        end
        quiet(20);

        // Random mix of reads and writes over a small address window
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            clr_start = 1'b0;
            scan_req  = ($urandom_range(0, 99) < 55);
            scan_addr = ADDR_W'($urandom_range(0, 31));
            wr_valid  = ($urandom_range(0, 99) < 60);
            wr_addr   = ADDR_W'($urandom_range(0, 31));
            wr_data   = DATA_W'($urandom);
            step();
        end
        quiet(50);

        // Clear with two writes pending and scan reads on alternate cycles
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            scan_req  = 1'b1;
            scan_addr = ADDR_W'(16'h200 + k);
            wr_valid  = 1'b1;
            wr_addr   = ADDR_W'(16'h200 + k);
            wr_data   = DATA_W'(12'h555 + k);
            step();
        end
        @(negedge clk);
        drive_idle();
        clr_start = 1'b1;
        clr_color = 12'h0F0;
        step();
        n = 0;
        while (mode != 0 && n < 60000) begin
            @(negedge clk);
            scan_req  = ~scan_req;
            scan_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_valid  = $urandom_range(0, 1);
            wr_addr   = ADDR_W'($urandom_range(0, 31));
            wr_data   = DATA_W'($urandom);
            clr_start = ($urandom_range(0, 999) == 0);
            clr_color = DATA_W'($urandom);
            step();
            n++;
        end
        check("clear_finished_mode", mode, 0);
        check("clear_cycles_in_range", int'(n > 38000 && n < 38800), 1);
        quiet(20);
        check("clr_done_pulses", done_seen, 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== 12'h0F0) bad++;
        check("clear_bad_words", bad, 0);

        // Second clear aborted by reset once word 5000 is next
        @(negedge clk);
        drive_idle();
        clr_start = 1'b1;
        clr_color = 12'h00F;
        step();
        n = 0;
        while (!(mode == 2 && mcnt == 5000) && n < 20000) begin
            @(negedge clk);
            drive_idle();
            step();
            n++;
        end
        check("abort_reached_word", mcnt, 5000);
        @(negedge clk);
        drive_idle();
        rstn = 1'b0;
        pend.delete();
        rq.delete();
        mode = 0;
        done_flag = 1'b0;
        #1;
        check("abort_ram_en", int'(ram_en), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_wr_ready", int'(wr_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        quiet(10);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 5000 && ram[i] !== 12'h00F) bad++;
            if (i >= 5000 && ram[i] !== 12'h0F0) bad++;
        end
        check("abort_bad_words", bad, 0);

        check("write_queue_leftover", wq.size(), 0);
        check("read_queue_leftover", rq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
